// File: rtl/rom_port_arbiter_if.sv
// rom_port_arbiter_if
// Bundles the two requester read ports and the ROM read port that
// rom_port_arbiter shares between the VGA pixel fetcher and the NPU tile loader.
//
// Signals
//   vga_req/vga_addr    VGA read request and address (held until granted)
//   vga_gnt             VGA read accepted this cycle
//   vga_valid/vga_data  VGA read data, one-cycle valid pulse
//   npu_*               same set for the NPU tile loader
//   mem_addr/mem_q      ROM address out, ROM data back
//   vga_miss            VGA request denied this cycle (forced NPU slot)
//   starve_cnt          NPU starvation count (debug)
//
// Modports
//   slave   arbiter side
//   master  requesters + ROM side (testbench / system)
interface rom_port_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
);
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_valid;
  logic [DATA_W-1:0] vga_data;

  logic              npu_req;
  logic [ADDR_W-1:0] npu_addr;
  logic              npu_gnt;
  logic              npu_valid;
  logic [DATA_W-1:0] npu_data;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_q;

  logic              vga_miss;
  logic [3:0]        starve_cnt;

  modport slave (
    input  vga_req, vga_addr, npu_req, npu_addr, mem_q,
    output vga_gnt, vga_valid, vga_data,
    output npu_gnt, npu_valid, npu_data,
    output mem_addr, vga_miss, starve_cnt
  );

  modport master (
    output vga_req, vga_addr, npu_req, npu_addr, mem_q,
    input  vga_gnt, vga_valid, vga_data,
    input  npu_gnt, npu_valid, npu_data,
    input  mem_addr, vga_miss, starve_cnt
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
// Shares one read port of the source-image ROM between the VGA pixel fetcher
// and the NPU tile loader. VGA has priority; after MAX_STARVE consecutive
// denied NPU cycles the NPU is forced to win one slot. Read data is steered
// back to the issuing requester through a {valid, owner} tag pipeline, so a
// grant at cycle t gives a valid pulse at t+READ_LAT+1.
//
// Ports
//   clk_i   system clock
//   rst_i   synchronous reset, active-high
//   bus     rom_port_arbiter_if.slave (requester ports, ROM port, debug)
//
// Parameters
//   ADDR_W      ROM address width
//   DATA_W      pixel width
//   READ_LAT    ROM cycles from address to q (1..4)
//   MAX_STARVE  denied NPU cycles before the NPU is forced to win (1..15)
module rom_port_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 8,
  parameter int READ_LAT   = 1,
  parameter int MAX_STARVE = 4
) (
  input logic                clk_i,
  input logic                rst_i,
  rom_port_arbiter_if.slave  bus
);

  if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
    $error("rom_port_arbiter: READ_LAT must be 1..4");
  end
  if (MAX_STARVE < 1 || MAX_STARVE > 15) begin : g_bad_starve
    $error("rom_port_arbiter: MAX_STARVE must be 1..15");
  end

  localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

  logic [3:0]        starve_q, starve_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  // tag_v_q[i]/tag_o_q[i]: read issued i+1 cycles ago, owner 1 = NPU
  logic [READ_LAT-1:0] tag_v_q;
  logic [READ_LAT-1:0] tag_o_q;

  logic              vga_valid_q, npu_valid_q;
  logic [DATA_W-1:0] vga_data_q, npu_data_q;

  logic force_npu;
  logic vga_gnt;
  logic npu_gnt;
  logic any_gnt;
  logic ret_v;
  logic ret_npu;

  // Arbitration: VGA first unless the NPU has been denied MAX_STARVE times
  // in a row while both are requesting.
  always_comb begin
    force_npu = bus.vga_req & bus.npu_req & (starve_q == STARVE_MAX);
    vga_gnt   = bus.vga_req & ~force_npu;
    npu_gnt   = bus.npu_req & (~bus.vga_req | force_npu);
    any_gnt   = vga_gnt | npu_gnt;
  end

  // Address mux falls back to the last granted address so the ROM input
  // stays stable between reads.
  always_comb begin
    mem_addr_d = mem_addr_q;
    if (vga_gnt) begin
      mem_addr_d = bus.vga_addr;
    end else if (npu_gnt) begin
      mem_addr_d = bus.npu_addr;
    end
  end

  always_comb begin
    starve_d = 4'd0;
    if (bus.npu_req && !npu_gnt) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 4'd1;
    end
  end

  // Oldest tag lines up with mem_q for the read it describes.
  always_comb begin
    ret_v   = tag_v_q[READ_LAT-1];
    ret_npu = tag_o_q[READ_LAT-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q    <= 4'd0;
      mem_addr_q  <= '0;
      tag_v_q     <= '0;
      tag_o_q     <= '0;
      vga_valid_q <= 1'b0;
      npu_valid_q <= 1'b0;
      vga_data_q  <= '0;
      npu_data_q  <= '0;
    end else begin
      starve_q   <= starve_d;
      mem_addr_q <= mem_addr_d;

      tag_v_q[0] <= any_gnt;
      tag_o_q[0] <= npu_gnt;
      for (int i = 1; i < READ_LAT; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_o_q[i] <= tag_o_q[i-1];
      end

      vga_valid_q <= ret_v & ~ret_npu;
      npu_valid_q <= ret_v & ret_npu;
      if (ret_v && !ret_npu) begin
        vga_data_q <= bus.mem_q;
      end
      if (ret_v && ret_npu) begin
        npu_data_q <= bus.mem_q;
      end
    end
  end

  assign bus.vga_gnt    = vga_gnt;
  assign bus.npu_gnt    = npu_gnt;
  assign bus.mem_addr   = mem_addr_d;
  assign bus.vga_miss   = force_npu;
  assign bus.starve_cnt = starve_q;
  assign bus.vga_valid  = vga_valid_q;
  assign bus.npu_valid  = npu_valid_q;
  assign bus.vga_data   = vga_data_q;
  assign bus.npu_data   = npu_data_q;

endmodule
